usb_pkt_tx: RTL

- Device-side USB 2.0 packet transmitter.
- Accepts a PID, plus an optional payload byte stream over a valid/ready handshake.
- Emits the PID byte, the payload and the CRC16 to a UTMI-style 8-bit transmit interface, then enforces an inter-packet gap.
- It is the transmit counterpart of the packet receiver/decoder. The endpoint/protocol engine drives it for DATA0/DATA1 and handshake (ACK/NAK/STALL) responses.

---
 rtl/usb_pkg.sv | 43 ++++
 rtl/usb_crc16.sv | 13 +
 rtl/usb_pkt_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// USB device-side shared types, PID codes and CRC16 helper.
// Imported by the packet transmitter and its CRC sub-module.
package usb_pkg;

  typedef logic [3:0] pid_t;
  typedef logic [7:0] bus8_t;

  localparam pid_t PID_DATA0 = 4'b0011;
  localparam pid_t PID_DATA1 = 4'b1011;
  localparam pid_t PID_DATA2 = 4'b0111;
  localparam pid_t PID_MDATA = 4'b1111;
  localparam pid_t PID_ACK   = 4'b0010;
  localparam pid_t PID_NAK   = 4'b1010;
  localparam pid_t PID_STALL = 4'b1110;
  localparam pid_t PID_NYET  = 4'b0110;

  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_DATA,
    TX_CRC_LO,
    TX_CRC_HI,
    TX_DRAIN,
    TX_GAP
  } tx_state_e;

  // LSB-first byte update, unrolled into 8 bit steps
  function automatic logic [15:0] crc16_byte(
    input logic [15:0] crc,
    input bus8_t       b
  );
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC16_POLY_R;
      else      c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Combinational byte-wide CRC16 update.
// Shared between the transmitter and the receiver check path.
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] crc_i,
  input  bus8_t       data_i,
  output logic [15:0] crc_o
);

  assign crc_o = crc16_byte(crc_i, data_i);

endmodule

// File: rtl/usb_pkt_tx.sv
// USB 2.0 device packet transmitter onto a UTMI 8-bit tx port.
// Sends PID, optional payload and CRC16, then holds an IPG.
module usb_pkt_tx
  import usb_pkg::*;
#(
  parameter int MAX_PKT_SIZE = 64,
  parameter int IPG_CYCLES   = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tx_start,
  input  pid_t  tx_pid,
  input  logic  tx_zlp,
  input  bus8_t s_data,
  input  logic  s_valid,
  input  logic  s_last,
  output logic  s_ready,
  output bus8_t utmi_data,
  output logic  utmi_txvalid,
  input  logic  utmi_txready,
  output logic  busy,
  output logic  done,
  output logic  err
);

  localparam logic [10:0] MAX_L =
    11'(MAX_PKT_SIZE);
  localparam logic [15:0] IPG_LAST =
    16'((IPG_CYCLES == 0) ? 0 : IPG_CYCLES - 1);

  tx_state_e   state_q, state_d;
  bus8_t       data_q, data_d;
  logic        txv_q, txv_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] crc_q, crc_d;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] crc_nxt;
  logic [10:0] cnt_inc;
  logic        ld_ok;

  usb_crc16 u_crc (
    .crc_i  (crc_q),
    .data_i (s_data),
    .crc_o  (crc_nxt)
  );

  assign ld_ok   = !txv_q || utmi_txready;
  assign cnt_inc = cnt_q + 11'd1;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    txv_d   = txv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    s_ready = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          data_d = {~tx_pid, tx_pid};
          txv_d  = 1'b1;
          busy_d = 1'b1;
          crc_d  = CRC16_INIT;
          cnt_d  = '0;
          if (tx_pid[1:0] == 2'b11)
            state_d = tx_zlp ? TX_CRC_LO : TX_DATA;
          else
            state_d = TX_DRAIN;
        end
      end
      TX_DATA: begin
        s_ready = ld_ok;
        if (ld_ok) begin
          if (s_valid) begin
            data_d = s_data;
            crc_d  = crc_nxt;
            cnt_d  = cnt_inc;
            if (s_last || cnt_inc == MAX_L)
              state_d = TX_CRC_LO;
            if (!s_last && cnt_inc == MAX_L)
              err_d = 1'b1;
          end else begin
            // source starved: abort, receiver sees bad CRC
            txv_d = 1'b0;
            err_d = 1'b1;
            if (IPG_CYCLES == 0) begin
              busy_d  = 1'b0;
              state_d = TX_IDLE;
            end else begin
              gap_d   = '0;
              state_d = TX_GAP;
            end
          end
        end
      end
      TX_CRC_LO: begin
        if (ld_ok) begin
          data_d  = ~crc_q[7:0];
          state_d = TX_CRC_HI;
        end
      end
      TX_CRC_HI: begin
        if (ld_ok) begin
          data_d  = ~crc_q[15:8];
          state_d = TX_DRAIN;
        end
      end
      TX_DRAIN: begin
        if (utmi_txready) begin
          txv_d  = 1'b0;
          done_d = 1'b1;
          if (IPG_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = TX_IDLE;
          end else begin
            gap_d   = '0;
            state_d = TX_GAP;
          end
        end
      end
      TX_GAP: begin
        if (gap_q == IPG_LAST) begin
          busy_d  = 1'b0;
          state_d = TX_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      data_q  <= 8'h00;
      txv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crc_q   <= CRC16_INIT;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      txv_q   <= txv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign utmi_data    = data_q;
  assign utmi_txvalid = txv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
